// File: rtl/ahb_addr_decoder.sv
// AHB address decoder: one-hot slave select from the upper address bits, data-phase select
// registers and a default slave. Define DEFSLV_ERR_EN to build the two-cycle ERROR response.
module ahb_addr_decoder #(
   parameter int NUM_SLAVES = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int SEL_BITS   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [ADDR_WIDTH-1:0] i_haddr,
   input  logic [1:0]            i_htrans,
   input  logic                  i_hready,
   output logic                  o_hsel [NUM_SLAVES],
   output logic                  o_hsel_dp [NUM_SLAVES],
   output logic                  o_def_sel_dp,
   output logic                  o_def_hready,
   output logic                  o_def_hresp
);

   logic [SEL_BITS-1:0] idx;
   logic [31:0]         idx_ext;
   logic                mapped;
   logic                hsel_dp_q [NUM_SLAVES];
   logic                def_sel_dp_q;
   logic                unused_bits;

   assign idx     = i_haddr[ADDR_WIDTH-1 -: SEL_BITS];
   assign idx_ext = 32'(idx);
   assign mapped  = idx_ext < 32'(NUM_SLAVES);

   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv
         assign o_hsel[gi] = (idx_ext == 32'(gi));

         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               hsel_dp_q[gi] <= 1'b0;
            end else if (i_hready) begin
               hsel_dp_q[gi] <= o_hsel[gi];
            end
         end

         assign o_hsel_dp[gi] = hsel_dp_q[gi];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         def_sel_dp_q <= 1'b0;
      end else if (i_hready) begin
         def_sel_dp_q <= !mapped;
      end
   end

   assign o_def_sel_dp = def_sel_dp_q;

`ifdef DEFSLV_ERR_EN
   localparam logic [1:0] DS_IDLE = 2'd0;
   localparam logic [1:0] DS_ERR1 = 2'd1;
   localparam logic [1:0] DS_ERR2 = 2'd2;

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       err_req;

   // Only active (NONSEQ/SEQ) transfers to an unmapped slot earn an ERROR response.
   assign err_req = i_hready && !mapped && i_htrans[1];

   always_comb begin
      state_d = DS_IDLE;
      case (state_q)
         DS_IDLE: state_d = err_req ? DS_ERR1 : DS_IDLE;
         DS_ERR1: state_d = DS_ERR2;
         DS_ERR2: state_d = err_req ? DS_ERR1 : DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= DS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign o_def_hready = (state_q != DS_ERR1);
   assign o_def_hresp  = (state_q != DS_IDLE);
   assign unused_bits  = ^{i_htrans[0], i_haddr[ADDR_WIDTH-SEL_BITS-1:0]};
`else
   assign o_def_hready = 1'b1;
   assign o_def_hresp  = 1'b0;
   assign unused_bits  = ^{i_htrans, i_haddr[ADDR_WIDTH-SEL_BITS-1:0]};
`endif

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Self-checking bench for ahb_addr_decoder: directed scenarios plus randomized traffic
// checked against a queue-based model of the default-slave response beats.
module tb_ahb_addr_decoder;

   localparam int NS = 2;
   localparam int AW = 32;
   localparam int SB = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] haddr = '0;
   logic [1:0]    htrans = 2'b00;
   logic          hready = 1'b1;
   logic          hsel [NS];
   logic          hsel_dp [NS];
   logic          def_sel_dp;
   logic          def_hready;
   logic          def_hresp;

   int total = 0;
   int bad = 0;

   // Model: owner of the data phase (-1 none, 0..NS-1 slave, NS default slave)
   // and a queue of pending default-slave beats {hready, hresp}; empty means OKAY zero-wait.
   int         exp_owner = -1;
   logic [1:0] beats [$];

   ahb_addr_decoder #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .SEL_BITS(SB)) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_haddr      (haddr),
      .i_htrans     (htrans),
      .i_hready     (hready),
      .o_hsel       (hsel),
      .o_hsel_dp    (hsel_dp),
      .o_def_sel_dp (def_sel_dp),
      .o_def_hready (def_hready),
      .o_def_hresp  (def_hresp)
   );

   always #5 clk = ~clk;

   function automatic int idx_of(input logic [AW-1:0] a);
      return int'(a >> (AW - SB));
   endfunction

   function automatic logic [1:0] cur_resp();
      if (beats.size() != 0) return beats[0];
      return 2'b10;
   endfunction

   function automatic void model_reset();
      exp_owner = -1;
      beats.delete();
   endfunction

   function automatic void model_edge();
      logic [1:0] now;
      int         ix;
      now = cur_resp();
      ix  = idx_of(haddr);
      if (beats.size() != 0) void'(beats.pop_front());
      if (hready) begin
         exp_owner = (ix < NS) ? ix : NS;
`ifdef DEFSLV_ERR_EN
         // During the wait beat the bus is stalled, so no new transfer is taken.
         if (now[1] && ix >= NS && htrans[1]) begin
            beats.push_back(2'b01);
            beats.push_back(2'b11);
         end
`endif
      end
   endfunction

   task automatic drive(input logic [AW-1:0] a, input logic [1:0] t, input logic r);
      haddr  = a;
      htrans = t;
      hready = r;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(32'h1000_0000, 2'b10, 1'b1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         total++;
         if (hsel_dp[i] !== 1'b0) begin
            bad++;
            $display("FAIL reset_hsel_dp[%0d] got=%b exp=0", i, hsel_dp[i]);
         end
      end
      total++;
      if ({def_sel_dp, def_hready, def_hresp} !== 3'b010) begin
         bad++;
         $display("FAIL reset_def got=%b%b%b exp=010", def_sel_dp, def_hready, def_hresp);
      end
      rstn = 1'b1;
      model_reset();
      $display("reset: released");
   endtask

   task automatic test_decode();
      drive(32'h1000_0000, 2'b10, 1'b1);
      #1;
      total++;
      if (hsel[0] !== 1'b0 || hsel[1] !== 1'b1) begin
         bad++;
         $display("FAIL decode_hsel got=%b%b exp=10", hsel[1], hsel[0]);
      end
      tick();
      total++;
      if (hsel_dp[0] !== 1'b0 || hsel_dp[1] !== 1'b1 || def_sel_dp !== 1'b0) begin
         bad++;
         $display("FAIL decode_dp got=%b%b%b exp=010", def_sel_dp, hsel_dp[1], hsel_dp[0]);
      end
      $display("decode: addr=%h hsel_dp=%b%b", haddr, hsel_dp[1], hsel_dp[0]);
   endtask

   task automatic test_hold();
      drive(32'h0000_0000, 2'b10, 1'b1);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(32'h1000_0000, 2'b10, 1'b0);
         tick();
         total++;
         if (hsel_dp[0] !== 1'b1 || hsel_dp[1] !== 1'b0) begin
            bad++;
            $display("FAIL hold_c%0d got=%b%b exp=01", c, hsel_dp[1], hsel_dp[0]);
         end
      end
      hready = 1'b1;
      tick();
      total++;
      if (hsel_dp[0] !== 1'b0 || hsel_dp[1] !== 1'b1) begin
         bad++;
         $display("FAIL hold_release got=%b%b exp=10", hsel_dp[1], hsel_dp[0]);
      end
      $display("hold: hsel_dp=%b%b after release", hsel_dp[1], hsel_dp[0]);
   endtask

   task automatic test_error();
      logic [1:0] exp_seq [3];
`ifdef DEFSLV_ERR_EN
      exp_seq = '{2'b01, 2'b11, 2'b10};
`else
      exp_seq = '{2'b10, 2'b10, 2'b10};
`endif
      drive(32'hF000_0000, 2'b10, 1'b1);
      tick();
      total++;
      if (def_sel_dp !== 1'b1 || hsel_dp[0] !== 1'b0 || hsel_dp[1] !== 1'b0) begin
         bad++;
         $display("FAIL error_def_sel got=%b%b%b exp=100", def_sel_dp, hsel_dp[1], hsel_dp[0]);
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({def_hready, def_hresp} !== exp_seq[k]) begin
            bad++;
            $display("FAIL error_beat%0d got=%b%b exp=%b", k, def_hready, def_hresp, exp_seq[k]);
         end
         $display("error: beat%0d hready=%b hresp=%b", k, def_hready, def_hresp);
         drive(32'h0000_0000, 2'b00, def_hready);
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addr_t [7];
      logic [1:0]    trans_t [7];
      logic          rdy_t [7];
      logic [1:0]    exp_t [7];
      addr_t  = '{default: 32'hF000_0000};
      trans_t = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
      rdy_t   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef DEFSLV_ERR_EN
      exp_t   = '{2'b10, 2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b10};
`else
      exp_t   = '{default: 2'b10};
`endif
      for (int c = 0; c < 7; c++) begin
         drive(addr_t[c], trans_t[c], rdy_t[c]);
         #1;
         total++;
         if ({def_hready, def_hresp} !== exp_t[c]) begin
            bad++;
            $display("FAIL b2b_c%0d got=%b%b exp=%b", c, def_hready, def_hresp, exp_t[c]);
         end
         $display("b2b: c%0d htrans=%b hready_in=%b -> %b%b", c, trans_t[c], rdy_t[c], def_hready, def_hresp);
         tick();
      end
   endtask

   task automatic test_async_reset();
      drive(32'h1000_0000, 2'b10, 1'b1);
      tick();
      drive(32'hF000_0000, 2'b10, 1'b1);
      tick();
      drive(32'hF000_0000, 2'b10, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if ({def_sel_dp, hsel_dp[1], hsel_dp[0], def_hready, def_hresp} !== 5'b00010) begin
         bad++;
         $display("FAIL async_reset got=%b%b%b%b%b exp=00010",
                  def_sel_dp, hsel_dp[1], hsel_dp[0], def_hready, def_hresp);
      end
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      drive(32'h1000_0000, 2'b10, 1'b1);
      #1;
      total++;
      if (hsel[1] !== 1'b1 || hsel[0] !== 1'b0 || def_hready !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_hsel got=%b%b rdy=%b exp=10 rdy=1", hsel[1], hsel[0], def_hready);
      end
      tick();
      total++;
      if (hsel_dp[1] !== 1'b1 || hsel_dp[0] !== 1'b0 || def_sel_dp !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_dp got=%b%b%b exp=010", def_sel_dp, hsel_dp[1], hsel_dp[0]);
      end
      $display("async_reset: recovered hsel_dp=%b%b", hsel_dp[1], hsel_dp[0]);
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic [1:0]    exp_r;
      int            ix;
      for (int n = 0; n < 300; n++) begin
         a = {4'($urandom_range(0, 15)), 28'($urandom)};
         drive(a, 2'($urandom), ($urandom_range(0, 3) != 0));
         ix = idx_of(a);
         #1;
         for (int i = 0; i < NS; i++) begin
            total++;
            if (hsel[i] !== (ix == i)) begin
               bad++;
               $display("FAIL rand%0d_hsel[%0d] got=%b exp=%b addr=%h", n, i, hsel[i], (ix == i), a);
            end
         end
         exp_r = cur_resp();
         total++;
         if ({def_hready, def_hresp} !== exp_r) begin
            bad++;
            $display("FAIL rand%0d_resp got=%b%b exp=%b", n, def_hready, def_hresp, exp_r);
         end
         tick();
         for (int i = 0; i < NS; i++) begin
            total++;
            if (hsel_dp[i] !== (exp_owner == i)) begin
               bad++;
               $display("FAIL rand%0d_hsel_dp[%0d] got=%b exp=%b", n, i, hsel_dp[i], (exp_owner == i));
            end
         end
         total++;
         if (def_sel_dp !== (exp_owner == NS)) begin
            bad++;
            $display("FAIL rand%0d_def_sel_dp got=%b exp=%b", n, def_sel_dp, (exp_owner == NS));
         end
         $display("rand: n=%0d addr=%h htrans=%b hready=%b owner=%0d", n, a, htrans, hready, exp_owner);
      end
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_decode();
      test_hold();
      test_error();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ahb_addr_decoder.md
AHB_ADDR_DECODER -- requirements
Module: ahb_addr_decoder

Interface
REQ-001 Parameter NUM_SLAVES, default 2, number of mapped slave ports.
REQ-002 Parameter ADDR_WIDTH, default 32, width of the address bus.
REQ-003 Parameter SEL_BITS, default 4, number of upper address bits used as the slave index.
REQ-004 i_clk  input  1  bus clock; one clock, all state on its rising edge.
REQ-005 i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 i_haddr  input  ADDR_WIDTH  master address-phase address.
REQ-007 i_htrans  input  2  master transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 i_hready  input  1  bus-wide HREADY returned to the master; advances address phase to data phase.
REQ-009 o_hsel  output  1 x NUM_SLAVES (unpacked)  address-phase slave select, combinational.
REQ-010 o_hsel_dp  output  1 x NUM_SLAVES (unpacked)  registered data-phase select; drives the i_hsel input of master_mux.
REQ-011 o_def_sel_dp  output  1  default slave owns the current data phase.
REQ-012 o_def_hready  output  1  default slave HREADYOUT.
REQ-013 o_def_hresp  output  1  default slave HRESP: 0=OKAY, 1=ERROR.

Function
REQ-014 Index idx = i_haddr[ADDR_WIDTH-1 -: SEL_BITS].
REQ-015 For idx < NUM_SLAVES, o_hsel[idx]=1 and all other bits are 0, regardless of i_htrans.
REQ-016 For idx >= NUM_SLAVES, all o_hsel bits are 0 and the address is unmapped.
REQ-017 On each rising edge with i_hready=1, o_hsel_dp <= o_hsel and o_def_sel_dp <= (idx >= NUM_SLAVES).
REQ-018 With i_hready=0, o_hsel_dp and o_def_sel_dp hold their values; latency from address phase to data-phase select is exactly one accepted cycle.
REQ-019 At most one bit of {o_hsel_dp, o_def_sel_dp} is 1 at any time.
REQ-020 Default-slave FSM states: DS_IDLE, DS_ERR1, DS_ERR2.
REQ-021 DS_IDLE -> DS_ERR1 on an edge with i_hready=1, unmapped idx and i_htrans[1]=1 (NONSEQ/SEQ); otherwise stay in DS_IDLE.
REQ-022 DS_ERR1 -> DS_ERR2 unconditionally on the next edge.
REQ-023 DS_ERR2 -> DS_ERR1 if i_hready=1 with a new unmapped NONSEQ/SEQ; otherwise -> DS_IDLE.
REQ-024 Outputs per state: DS_IDLE hready=1, hresp=0; DS_ERR1 hready=0, hresp=1; DS_ERR2 hready=1, hresp=1.
REQ-025 Unmapped IDLE/BUSY transfers receive a zero-wait OKAY (FSM stays in DS_IDLE).
REQ-026 Back-to-back unmapped NONSEQ transfers produce repeated ERR1/ERR2 pairs with no DS_IDLE cycle in between.
REQ-027 i_haddr and i_htrans are ignored in DS_ERR1 (i_hready is low on the bus).

Reset
REQ-028 While i_rstn=0: o_hsel_dp all 0, o_def_sel_dp=0, FSM=DS_IDLE, o_def_hready=1, o_def_hresp=0.
REQ-029 Reset assertion in any state, including mid ERROR response, takes effect immediately without waiting for a clock edge; the first transfer after release is decoded normally.

Configuration
REQ-030 Macro DEFSLV_ERR_EN defined: the default-slave FSM and two-cycle ERROR response of REQ-020..REQ-027 are implemented.
REQ-031 Macro DEFSLV_ERR_EN undefined: the FSM is not built; o_def_hready is constant 1 and o_def_hresp is constant 0 (all unmapped transfers OKAY, zero-wait), and o_def_sel_dp is still generated.

Verification
REQ-032 NUM_SLAVES=2, SEL_BITS=4: i_haddr=0x1000_0000, NONSEQ, i_hready=1 -> o_hsel={0,1} same cycle, o_hsel_dp[1]=1 after next edge.
REQ-033 i_hready held 0 for 3 cycles while the address changes from 0x0 to 0x1000_0000 -> o_hsel_dp stays [0]=1 until i_hready=1.
REQ-034 With DEFSLV_ERR_EN defined: 0xF000_0000 NONSEQ -> next cycle hready=0/hresp=1, then hready=1/hresp=1, then DS_IDLE with OKAY.
REQ-035 Two consecutive unmapped NONSEQ transfers -> ERR1,ERR2,ERR1,ERR2 with no idle gap; unmapped IDLE transfer -> OKAY, no wait state.
REQ-036 Assert i_rstn=0 in DS_ERR1 -> hready=1, hresp=0 and o_hsel_dp=0 asynchronously; after release, a mapped NONSEQ decodes normally.
REQ-037 With DEFSLV_ERR_EN undefined: 0xF000_0000 NONSEQ -> o_def_sel_dp=1, hready=1, hresp=0 for every cycle.
